// File: rtl/random_range_sampler_pkg.sv
// Shared definitions for consumers of the free-running LFSR word stream:
// sampler FSM state encoding and default sizing.
package random_range_sampler_pkg;

  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_MAX_TRIES = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREP   = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } samplerState_t;

endpackage

// File: rtl/range_mask_gen.sv
// Leading-one smear: produces the smallest 2^k-1 mask that covers value.
module range_mask_gen #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] mask
);

  logic seenOne;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    seenOne = 1'b0;
    mask    = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      seenOne = seenOne | value[i];
      mask[i] = seenOne;
    end
  end

endmodule

// File: rtl/random_range_sampler.sv
// Masked rejection sampler: converts LFSR words into an unbiased value in
// [0, bound) with a bounded retry count and a deterministic fallback.
module random_range_sampler
  import random_range_sampler_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_TRIES = DEFAULT_MAX_TRIES,
  parameter int STRIDE    = 1
) (
  input  logic             iClock,
  input  logic             iResetN,
  input  logic [31:0]      iRandom,
  input  logic             iReq,
  input  logic [WIDTH-1:0] iBound,
  output logic             oReqReady,
  output logic [WIDTH-1:0] oValue,
  output logic             oValid,
  input  logic             iAck,
  output logic             oFallback
);

  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  samplerState_t    state;
  logic [WIDTH-1:0] bnd;
  logic [WIDTH-1:0] mask;
  logic [TW-1:0]    tryCount;
  logic [SW-1:0]    strideCnt;

  logic [WIDTH-1:0] bndMinusOne;
  logic [WIDTH-1:0] maskNext;
  logic [WIDTH-1:0] cand;

  // bnd-1 only matters for bnd >= 2; smaller bounds short-circuit in PREP.
  assign bndMinusOne = (bnd >= WIDTH'(2)) ? bnd - WIDTH'(1) : '0;
  assign cand        = iRandom[WIDTH-1:0] & mask;

  range_mask_gen #(.WIDTH(WIDTH)) uMaskGen (
    .value (bndMinusOne),
    .mask  (maskNext)
  );

  if (WIDTH < 32) begin : genUnusedRandom
    logic unusedRandomBits;
    assign unusedRandomBits = ^iRandom[31:WIDTH];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      state     <= IDLE;
      bnd       <= '0;
      mask      <= '0;
      tryCount  <= '0;
      strideCnt <= '0;
      oValue    <= '0;
      oValid    <= 1'b0;
      oFallback <= 1'b0;
      oReqReady <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (iReq) begin
            bnd       <= iBound;
            oReqReady <= 1'b0;
            state     <= PREP;
          end
        end

        PREP: begin
          mask      <= maskNext;
          tryCount  <= '0;
          strideCnt <= '0;
          if (bnd <= WIDTH'(1)) begin
            oValue    <= '0;
            oFallback <= 1'b0;
            oValid    <= 1'b1;
            state     <= HOLD;
          end else begin
            state <= SAMPLE;
          end
        end

        SAMPLE: begin
          if (strideCnt == '0) begin
            strideCnt <= SW'(STRIDE - 1);
            if (cand < bnd) begin
              oValue    <= cand;
              oFallback <= 1'b0;
              oValid    <= 1'b1;
              state     <= HOLD;
            end else if (tryCount == TW'(MAX_TRIES - 1)) begin
              // mask < 2*bnd, so cand - bnd is always inside the range.
              oValue    <= cand - bnd;
              oFallback <= 1'b1;
              oValid    <= 1'b1;
              state     <= HOLD;
            end else begin
              tryCount <= tryCount + TW'(1);
            end
          end else begin
            strideCnt <= strideCnt - SW'(1);
          end
        end

        HOLD: begin
          if (iAck) begin
            oValid    <= 1'b0;
            oReqReady <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_random_range_sampler.sv
// Self-checking bench: directed and random requests against a behavioural
// model of masked rejection sampling, on STRIDE=1 and STRIDE=4 instances.
module tb_random_range_sampler;

  localparam int MAX_TRIES = 8;

  logic        iClock;
  logic        iResetN;
  logic [31:0] iRandom;
  logic [15:0] iBound;
  logic        iAck;
  logic        reqA, reqB;
  logic        readyA, validA, fbA;
  logic        readyB, validB, fbB;
  logic [15:0] valueA, valueB;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] rnd [0:63];
  bit          curS4;

  random_range_sampler #(.WIDTH(16), .MAX_TRIES(MAX_TRIES), .STRIDE(1)) dutA (
    .iClock(iClock), .iResetN(iResetN), .iRandom(iRandom), .iReq(reqA),
    .iBound(iBound), .oReqReady(readyA), .oValue(valueA), .oValid(validA),
    .iAck(iAck), .oFallback(fbA)
  );

  random_range_sampler #(.WIDTH(16), .MAX_TRIES(MAX_TRIES), .STRIDE(4)) dutB (
    .iClock(iClock), .iResetN(iResetN), .iRandom(iRandom), .iReq(reqB),
    .iBound(iBound), .oReqReady(readyB), .oValue(valueB), .oValid(validB),
    .iAck(iAck), .oFallback(fbB)
  );

  logic        selReady, selValid, selFb;
  logic [15:0] selValue;
  assign selReady = curS4 ? readyB : readyA;
  assign selValid = curS4 ? validB : validA;
  assign selFb    = curS4 ? fbB    : fbA;
  assign selValue = curS4 ? valueB : valueA;

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference: sample k happens in cycle 2 + k*stride using the smallest
  // all-ones mask covering bound-1; result is visible the cycle after.
  function automatic void model(input int bound, input int stride,
                                output int validCycle, output int value, output bit fallback);
    int m, sc, c;
    validCycle = 2; value = 0; fallback = 1'b0;
    if (bound <= 1) return;
    m = 0;
    while (m < bound - 1) m = m * 2 + 1;
    for (int t = 0; t < MAX_TRIES; t++) begin
      sc = 2 + t * stride;
      c  = int'(rnd[sc] & 32'hFFFF) & m;
      validCycle = sc + 1;
      if (c < bound) begin
        value = c;
        return;
      end
      if (t == MAX_TRIES - 1) begin
        value    = c - bound;
        fallback = 1'b1;
      end
    end
  endfunction

  task automatic fillRnd(input logic [31:0] v);
    for (int i = 0; i < 64; i++) rnd[i] = v;
  endtask

  task automatic runRequest(input int bound, input bit useS4, input int ackDelay, input bit pokeReq);
    int expCycle, expVal, gotCycle;
    bit expFb;
    curS4 = useS4;
    model(bound, useS4 ? 4 : 1, expCycle, expVal, expFb);
    @(negedge iClock);
    check("ready_idle", {31'b0, selReady}, 32'd1);
    iBound  = 16'(bound);
    iRandom = rnd[0];
    reqA    = !useS4;
    reqB    = useS4;
    gotCycle = -1;
    for (int c = 1; c <= 48 && gotCycle < 0; c++) begin
      @(negedge iClock);
      reqA    = 1'b0;
      reqB    = 1'b0;
      iRandom = rnd[c];
      iBound  = 16'($urandom);
      if (c == 1) check("ready_busy", {31'b0, selReady}, 32'd0);
      if (selValid) gotCycle = c;
    end
    check("valid_cycle", gotCycle, expCycle);
    check("value", {16'b0, selValue}, expVal);
    check("fallback", {31'b0, selFb}, {31'b0, expFb});
    for (int k = 0; k < ackDelay; k++) begin
      @(negedge iClock);
      reqA = pokeReq && !useS4 && (k == 0);
      reqB = pokeReq && useS4 && (k == 0);
      check("hold_valid", {31'b0, selValid}, 32'd1);
      check("hold_value", {16'b0, selValue}, expVal);
      check("hold_ready", {31'b0, selReady}, 32'd0);
    end
    reqA = 1'b0;
    reqB = 1'b0;
    iAck = 1'b1;
    @(negedge iClock);
    iAck = 1'b0;
    check("ack_valid", {31'b0, selValid}, 32'd0);
    check("ack_ready", {31'b0, selReady}, 32'd1);
    @(negedge iClock);
    check("idle_stays", {31'b0, selReady}, 32'd1);
  endtask

  initial begin
    int bound, pick;
    iResetN = 1'b0;
    iRandom = '0;
    iBound  = '0;
    iAck    = 1'b0;
    reqA    = 1'b0;
    reqB    = 1'b0;
    curS4   = 1'b0;
    repeat (3) @(negedge iClock);
    check("rst_valid", {31'b0, validA}, 32'd0);
    check("rst_value", {16'b0, valueA}, 32'd0);
    check("rst_fb", {31'b0, fbA}, 32'd0);
    check("rst_ready", {30'b0, readyA, readyB}, 32'd3);
    iResetN = 1'b1;
    @(negedge iClock);

    // Immediate acceptance, then full rejection run into the fallback.
    fillRnd(32'h0000_0007); runRequest(10, 1'b0, 1, 1'b0);
    fillRnd(32'hABCD_000C); runRequest(10, 1'b0, 0, 1'b0);
    // Degenerate bounds never sample.
    fillRnd(32'hFFFF_FFFF); runRequest(0, 1'b0, 0, 1'b0);
    runRequest(1, 1'b0, 2, 1'b0);
    // Long hold with an ignored request in the middle.
    for (int i = 0; i < 64; i++) rnd[i] = $urandom;
    rnd[2] = 32'h0000_03E7;
    runRequest(1000, 1'b0, 5, 1'b1);
    // Stride 4: only cycles 2 and 6 are sampled.
    fillRnd(32'h0000_000C);
    for (int i = 2; i < 64; i++) begin
      case ((i - 2) % 5)
        0: rnd[i] = 32'h0000_000C;
        1: rnd[i] = 32'h0000_000D;
        2: rnd[i] = 32'h0000_000E;
        3: rnd[i] = 32'h0000_000F;
        default: rnd[i] = 32'h0000_0003;
      endcase
    end
    runRequest(10, 1'b1, 1, 1'b0);
    // Maximal bound uses the full mask.
    fillRnd(32'h1234_FFFF); runRequest(16'hFFFF, 1'b0, 0, 1'b0);

    // Asynchronous reset in the middle of SAMPLE.
    curS4 = 1'b0;
    fillRnd(32'h0000_000C);
    @(negedge iClock);
    iBound = 16'd10; iRandom = rnd[0]; reqA = 1'b1;
    @(negedge iClock);
    reqA = 1'b0;
    repeat (3) @(negedge iClock);
    #1 iResetN = 1'b0;
    #1;
    check("arst_valid", {31'b0, validA}, 32'd0);
    check("arst_value", {16'b0, valueA}, 32'd0);
    check("arst_fb", {31'b0, fbA}, 32'd0);
    check("arst_ready", {31'b0, readyA}, 32'd1);
    @(negedge iClock);
    iResetN = 1'b1;
    fillRnd(32'h0000_0005); runRequest(10, 1'b0, 0, 1'b0);

    // Randomised requests on both instances.
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 3);
      case (pick)
        0: bound = $urandom_range(0, 3);
        1: bound = $urandom_range(2, 20);
        2: bound = $urandom_range(0, 65535);
        default: bound = 65535;
      endcase
      for (int i = 0; i < 64; i++) rnd[i] = $urandom;
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < 64; i++) rnd[i] = rnd[i] | 32'h0000_FFF0;
      runRequest(bound, n[0], $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
